// File: rtl/mos_rq_pkg.sv
// mos_rq_pkg
//   Shared types and constants for the MOS result requantiser slice.
//   IN_W/OUT_W   : widths of the raw MOS result and the requantised result
//   SAT_MAX/MIN  : clamp limits of the 16-bit signed output
//   rq_entry_t   : one FIFO entry, {last tag, 16-bit signed data}
//   rq_state_t   : frame tracker states
package mos_rq_pkg;

  localparam int IN_W    = 40;
  localparam int OUT_W   = 16;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef struct packed {
    logic                    last;
    logic signed [OUT_W-1:0] data;
  } rq_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } rq_state_t;

endpackage

// File: rtl/mos_rq_fifo.sv
// mos_rq_fifo
//   Generic synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and read hold)
//   push/wdata : write request and data; a push while full is accepted only with a pop
//   pop        : consume the head entry (ignored when empty)
//   rdata      : head entry; when empty it keeps the last entry that was popped
//   full/empty : occupancy flags
module mos_rq_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_hold;
  logic             w_wrEn;
  logic             w_rdEn;
  logic [WIDTH-1:0] w_head;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign empty  = (r_wrPtr == r_rdPtr);
  assign w_rdEn = pop && !empty;
  // A push into a full FIFO lands in the slot that the simultaneous pop frees.
  assign w_wrEn = push && (!full || w_rdEn);
  assign w_head = r_mem[r_rdPtr[AW-1:0]];
  assign rdata  = empty ? r_hold : w_head;

  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr[AW-1:0]] <= wdata;
    end
  end

  // r_hold remembers the last popped entry so the output stays put once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_hold  <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdEn) begin
        r_rdPtr <= r_rdPtr + 1'b1;
        r_hold  <= w_head;
      end
    end
  end

endmodule

// File: rtl/mos_result_requant.sv
// mos_result_requant
//   Rounds and saturates the 40-bit signed MOS result stream to 16-bit signed, tags the
//   last element of each matrix and buffers the results in a FWFT FIFO drained through a
//   valid/ready handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : MOS result strobe (no backpressure towards MOS)
//   matrix_size  : 0 = FRAME_S results per matrix, 1 = FRAME_L; sampled on a frame's first beat
//   in_data      : 40-bit signed MOS result
//   out_ready    : consumer accepts the current beat
//   out_valid    : out_data/out_last hold a valid beat
//   out_data     : rounded, saturated 16-bit signed result
//   out_last     : last element of the current matrix
//   ovf_err      : sticky, a beat was dropped because the FIFO was full
//   sat_cnt      : saturating count of stored beats that clamped; only when
//                  MOS_RQ_SATCNT_EN is defined
module mos_result_requant
  import mos_rq_pkg::*;
#(
  parameter int SHIFT   = 8,
  parameter int DEPTH   = 64,
  parameter int FRAME_S = 16,
  parameter int FRAME_L = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    matrix_size,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic                    ovf_err
`ifdef MOS_RQ_SATCNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int CNT_W = $clog2(FRAME_L + 1);
  localparam logic signed [IN_W:0] ROUND_C =
    (SHIFT == 0) ? '0 : ((IN_W+1)'(1) <<< ((SHIFT > 0) ? (SHIFT - 1) : 0));
  localparam logic signed [IN_W:0] MAX_W = (IN_W+1)'(SAT_MAX);
  localparam logic signed [IN_W:0] MIN_W = (IN_W+1)'(SAT_MIN);

  logic signed [IN_W:0]    w_sum;
  logic signed [IN_W:0]    w_shift;
  logic                    w_satHi;
  logic                    w_satLo;
  logic signed [OUT_W-1:0] w_rq;
  logic [CNT_W-1:0]        w_newLen;
  logic                    w_last;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  rq_entry_t               w_rdEntry;

  rq_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_pipeValid;
  rq_entry_t        r_pipeEntry;
  logic             r_ovf;

  // One guard bit above the input width keeps the rounding add from wrapping.
  assign w_sum   = $signed({in_data[IN_W-1], in_data}) + ROUND_C;
  assign w_shift = w_sum >>> SHIFT;
  assign w_satHi = (w_shift > MAX_W);
  assign w_satLo = (w_shift < MIN_W);
  assign w_rq    = w_satHi ? OUT_W'(SAT_MAX) :
                   w_satLo ? OUT_W'(SAT_MIN) : w_shift[OUT_W-1:0];

  assign w_newLen = matrix_size ? CNT_W'(FRAME_L) : CNT_W'(FRAME_S);

  // The first beat of a frame is also its last when the frame length is one.
  always_comb begin
    w_last = 1'b0;
    if (in_valid) begin
      if (r_state == ST_IDLE) begin
        w_last = (w_newLen == CNT_W'(1));
      end else begin
        w_last = (r_cnt == r_len - CNT_W'(1));
      end
    end
  end

  // Pipe register plus frame tracker; the length is latched only on a frame's first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_pipeValid <= 1'b0;
      r_pipeEntry <= '0;
    end else begin
      r_pipeValid <= in_valid;
      if (in_valid) begin
        r_pipeEntry <= '{last: w_last, data: w_rq};
        case (r_state)
          ST_IDLE: begin
            r_len <= w_newLen;
            r_cnt <= CNT_W'(1);
            if (!w_last) begin
              r_state <= ST_RECV;
            end
          end
          ST_RECV: begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_pop = out_valid && out_ready;

  mos_rq_fifo #(
    .WIDTH($bits(rq_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_pipeValid),
    .wdata (r_pipeEntry),
    .pop   (w_pop),
    .rdata (w_rdEntry),
    .full  (w_full),
    .empty (w_empty)
  );

  // A beat is lost only when it meets a full FIFO without a pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_pipeValid && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_rdEntry.data;
  assign out_last  = w_rdEntry.last;
  assign ovf_err   = r_ovf;

`ifdef MOS_RQ_SATCNT_EN
  logic        r_pipeSat;
  logic [15:0] r_satCnt;

  // Counts only beats that actually enter the FIFO, and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipeSat <= 1'b0;
      r_satCnt  <= '0;
    end else begin
      if (in_valid) begin
        r_pipeSat <= w_satHi || w_satLo;
      end
      if (r_pipeValid && r_pipeSat && (!w_full || w_pop) && (r_satCnt != 16'hFFFF)) begin
        r_satCnt <= r_satCnt + 16'd1;
      end
    end
  end

  assign sat_cnt = r_satCnt;
`endif

endmodule
